// File: rtl/atm_ctrl_multi.sv
//------------------------------------------------------------------------------
// atm_ctrl_multi
//   Multi-account ATM session controller. Holds NUM_ACCT accounts, each with a
//   balance, a PIN and a sticky lock bit. One card session at a time moves
//   through IDLE -> AUTH -> MENU, with EJECT as the holding state after a
//   lockout or an inactivity timeout. Every output is registered, so a
//   response appears one cycle after its strobe.
//
//   Optional feature macro: ATM_PIN_CHANGE_EN
//     defined   : mode 11 in MENU replaces the session account's PIN
//     undefined : mode 11 is rejected and stored PINs are fixed after reset
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   card     in   card present (level)
//   acct_id  in   account selector, captured when leaving IDLE
//   pin      in   entered PIN, qualified by pin_vld
//   pin_vld  in   one-cycle PIN strobe
//   req      in   one-cycle transaction strobe
//   mode     in   00 withdraw, 01 deposit, 10 inquiry, 11 PIN change
//   money    in   transaction amount, captured with req
//   new_pin  in   replacement PIN, captured with req when mode = 11
//   balance  out  balance of the session account
//   success  out  one-cycle accept pulse
//   error    out  one-cycle reject / lockout / timeout pulse
//   locked   out  session account is locked
//   busy     out  session in progress (not IDLE)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module atm_ctrl_multi #(
    parameter int unsigned AMT_W       = 17,
    parameter int unsigned PIN_W       = 17,
    parameter int unsigned NUM_ACCT    = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned INIT_BAL    = 1000,
    parameter int unsigned INIT_PIN    = 1211
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        card,
    input  logic [$clog2(NUM_ACCT)-1:0] acct_id,
    input  logic [PIN_W-1:0]            pin,
    input  logic                        pin_vld,
    input  logic                        req,
    input  logic [1:0]                  mode,
    input  logic [AMT_W-1:0]            money,
    input  logic [PIN_W-1:0]            new_pin,
    output logic [AMT_W-1:0]            balance,
    output logic                        success,
    output logic                        error,
    output logic                        locked,
    output logic                        busy
);

    localparam int unsigned ID_W  = $clog2(NUM_ACCT);
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_AUTH  = 2'b01;
    localparam logic [1:0] S_MENU  = 2'b10;
    localparam logic [1:0] S_EJECT = 2'b11;

    localparam logic [1:0] M_WDR = 2'b00;
    localparam logic [1:0] M_DEP = 2'b01;
    localparam logic [1:0] M_INQ = 2'b10;

    // Session state
    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  sess_q, sess_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Account storage
    logic [AMT_W-1:0]    acct_bal [NUM_ACCT];
    logic [PIN_W-1:0]    pin_mem  [NUM_ACCT];
    logic [NUM_ACCT-1:0] lock_mem;

    // Next values for the registered outputs
    logic [AMT_W-1:0] bal_d;
    logic             success_d;
    logic             error_d;
    logic             locked_d;
    logic             busy_d;

    // Storage write controls
    logic             bal_we;
    logic [AMT_W-1:0] bal_wdata;
    logic             lock_we;
`ifdef ATM_PIN_CHANGE_EN
    logic             pin_we;
`else
    logic             unused_new_pin;
    assign unused_new_pin = ^new_pin;
`endif

    // Datapath helpers for the session account
    logic [AMT_W-1:0] cur_bal;
    logic [PIN_W-1:0] cur_pin;
    logic [AMT_W:0]   dep_sum;
    logic [TRY_W-1:0] tries_inc;
    logic             tmo_hit;

    assign cur_bal   = acct_bal[sess_q];
    assign cur_pin   = pin_mem[sess_q];
    assign dep_sum   = {1'b0, cur_bal} + {1'b0, money};
    assign tries_inc = tries_q + TRY_W'(1);
    // The counter holds the number of idle cycles already elapsed, so the
    // cycle that would complete TIMEOUT_CYC idle cycles fires the timeout.
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, output and storage-write decode
    always_comb begin
        state_d   = state_q;
        sess_d    = sess_q;
        tries_d   = tries_q;
        tmo_d     = tmo_q;
        bal_d     = balance;
        success_d = 1'b0;
        error_d   = 1'b0;
        locked_d  = locked;
        bal_we    = 1'b0;
        bal_wdata = cur_bal;
        lock_we   = 1'b0;
`ifdef ATM_PIN_CHANGE_EN
        pin_we    = 1'b0;
`endif

        if (state_q != S_IDLE && !card) begin
            // Card removal wins over any strobe in the same cycle
            state_d  = S_IDLE;
            bal_d    = '0;
            locked_d = 1'b0;
            tries_d  = '0;
            tmo_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (card) begin
                        sess_d  = acct_id;
                        tries_d = '0;
                        tmo_d   = '0;
                        if (lock_mem[acct_id]) begin
                            state_d  = S_EJECT;
                            error_d  = 1'b1;
                            locked_d = 1'b1;
                        end else begin
                            state_d = S_AUTH;
                        end
                    end
                end

                S_AUTH: begin
                    if (pin_vld) begin
                        tmo_d = '0;
                        if (pin == cur_pin) begin
                            state_d = S_MENU;
                            tries_d = '0;
                            bal_d   = cur_bal;
                        end else begin
                            error_d = 1'b1;
                            tries_d = tries_inc;
                            if (tries_inc == TRY_W'(MAX_TRIES)) begin
                                lock_we  = 1'b1;
                                state_d  = S_EJECT;
                                locked_d = 1'b1;
                            end
                        end
                    end else if (tmo_hit) begin
                        error_d = 1'b1;
                        state_d = S_EJECT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end

                S_MENU: begin
                    if (req) begin
                        tmo_d = '0;
                        case (mode)
                            M_WDR: begin
                                if (money != '0 && money <= cur_bal) begin
                                    bal_we    = 1'b1;
                                    bal_wdata = cur_bal - money;
                                    bal_d     = cur_bal - money;
                                    success_d = 1'b1;
                                end else begin
                                    error_d = 1'b1;
                                end
                            end
                            M_DEP: begin
                                // Carry out of the widened sum means overflow
                                if (money != '0 && !dep_sum[AMT_W]) begin
                                    bal_we    = 1'b1;
                                    bal_wdata = dep_sum[AMT_W-1:0];
                                    bal_d     = dep_sum[AMT_W-1:0];
                                    success_d = 1'b1;
                                end else begin
                                    error_d = 1'b1;
                                end
                            end
                            M_INQ: begin
                                bal_d     = cur_bal;
                                success_d = 1'b1;
                            end
                            default: begin
`ifdef ATM_PIN_CHANGE_EN
                                if (new_pin == cur_pin) begin
                                    error_d = 1'b1;
                                end else begin
                                    pin_we    = 1'b1;
                                    success_d = 1'b1;
                                end
`else
                                error_d = 1'b1;
`endif
                            end
                        endcase
                    end else if (tmo_hit) begin
                        error_d = 1'b1;
                        state_d = S_EJECT;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end

                S_EJECT: begin
                    // Leaves only through the card-removal path above
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // Session counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sess_q  <= '0;
            tries_q <= '0;
            tmo_q   <= '0;
            balance <= '0;
            success <= 1'b0;
            error   <= 1'b0;
            locked  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            sess_q  <= sess_d;
            tries_q <= tries_d;
            tmo_q   <= tmo_d;
            balance <= bal_d;
            success <= success_d;
            error   <= error_d;
            locked  <= locked_d;
            busy    <= busy_d;
        end
    end

    // Account storage; lock bits are sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACCT; i++) begin
                acct_bal[i] <= AMT_W'(INIT_BAL);
                pin_mem[i]  <= PIN_W'(INIT_PIN);
            end
            lock_mem <= '0;
        end else begin
            if (bal_we) begin
                acct_bal[sess_q] <= bal_wdata;
            end
            if (lock_we) begin
                lock_mem[sess_q] <= 1'b1;
            end
`ifdef ATM_PIN_CHANGE_EN
            if (pin_we) begin
                pin_mem[sess_q] <= new_pin;
            end
`endif
        end
    end

endmodule
